// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the IF/MEM memory bus arbiter.
// Optional feature: MEM_ARB_RR_EN selects round-robin arbitration (see mem_bus_arbiter).
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } gnt_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between the instruction and data requesters.
// On a tie the requester that was not granted last wins; a constant last_gnt_i of INST gives data priority.
module mem_arb_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic inst_req_i,
    input  logic data_req_i,
    input  logic last_gnt_i,
    output logic gnt_valid_o,
    output logic gnt_o
);

    // Pick the winner among the pending requesters.
    always_comb begin
        gnt_valid_o = inst_req_i | data_req_i;
        gnt_o       = GNT_INST;
        if (inst_req_i && data_req_i) begin
            gnt_o = (last_gnt_i == GNT_INST) ? GNT_DATA : GNT_INST;
        end else if (data_req_i) begin
            gnt_o = GNT_DATA;
        end else begin
            gnt_o = GNT_INST;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between the IF and MEM ports with at most one transaction outstanding.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over inst.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [DATA_W-1:0]     inst_rdata,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [1:0]            data_size,
    input  logic [DATA_W/8-1:0]   data_wstrb,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [1:0]            bus_size,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    input  logic [DATA_W-1:0]     bus_rdata,
    output logic                  stallreq_for_bus
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                bus_wr_q, bus_wr_d;
    logic [1:0]          bus_size_q, bus_size_d;
    logic [STRB_W-1:0]   bus_wstrb_q, bus_wstrb_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
    logic                last_gnt_s, pick_valid_s, pick_gnt_s, load_s;
    logic                addr_hs_s, data_hs_s;

`ifdef MEM_ARB_RR_EN
    logic last_gnt_q, last_gnt_d;
    assign last_gnt_s = last_gnt_q;
    assign last_gnt_d = load_s ? pick_gnt_s : last_gnt_q;

    // Remember the last granted requester for tie-breaking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt_q <= GNT_INST;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    assign last_gnt_s = GNT_INST;
`endif

    mem_arb_pick u_pick (
        .inst_req_i  (inst_req),
        .data_req_i  (data_req),
        .last_gnt_i  (last_gnt_s),
        .gnt_valid_o (pick_valid_s),
        .gnt_o       (pick_gnt_s)
    );

    assign addr_hs_s = (state_q == ARB_ADDR) && bus_addr_ok;
    assign data_hs_s = (state_q == ARB_DATA) && bus_data_ok;

    // FSM next state; a completing DATA phase re-grants directly to avoid an IDLE bubble.
    always_comb begin
        state_d = state_q;
        load_s  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid_s) begin
                    load_s  = 1'b1;
                    state_d = ARB_ADDR;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ADDR: begin
                if (bus_addr_ok) begin
                    state_d = ARB_DATA;
                end else begin
                    state_d = ARB_ADDR;
                end
            end
            ARB_DATA: begin
                if (bus_data_ok && pick_valid_s) begin
                    load_s  = 1'b1;
                    state_d = ARB_ADDR;
                end else if (bus_data_ok) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_DATA;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Latch the granted request; inst is always a word read and reads never carry byte enables.
    always_comb begin
        gnt_d       = gnt_q;
        bus_wr_d    = bus_wr_q;
        bus_size_d  = bus_size_q;
        bus_wstrb_d = bus_wstrb_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if (load_s && (pick_gnt_s == GNT_DATA)) begin
            gnt_d       = GNT_DATA;
            bus_wr_d    = data_wr;
            bus_size_d  = data_size;
            bus_wstrb_d = data_wr ? data_wstrb : {STRB_W{1'b0}};
            bus_addr_d  = data_addr;
            bus_wdata_d = data_wdata;
        end else if (load_s) begin
            gnt_d       = GNT_INST;
            bus_wr_d    = 1'b0;
            bus_size_d  = SIZE_W;
            bus_wstrb_d = {STRB_W{1'b0}};
            bus_addr_d  = inst_addr;
            bus_wdata_d = {DATA_W{1'b0}};
        end else begin
            gnt_d = gnt_q;
        end
    end

    assign inst_rdata_d = (data_hs_s && (gnt_q == GNT_INST)) ? bus_rdata : inst_rdata_q;
    assign data_rdata_d = (data_hs_s && (gnt_q == GNT_DATA)) ? bus_rdata : data_rdata_q;

    // State, latched bus fields and per-port read data holding registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            gnt_q        <= GNT_INST;
            bus_wr_q     <= 1'b0;
            bus_size_q   <= 2'd0;
            bus_wstrb_q  <= {STRB_W{1'b0}};
            bus_addr_q   <= {ADDR_W{1'b0}};
            bus_wdata_q  <= {DATA_W{1'b0}};
            inst_rdata_q <= {DATA_W{1'b0}};
            data_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            bus_wr_q     <= bus_wr_d;
            bus_size_q   <= bus_size_d;
            bus_wstrb_q  <= bus_wstrb_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign bus_req      = (state_q == ARB_ADDR);
    assign bus_wr       = bus_wr_q;
    assign bus_size     = bus_size_q;
    assign bus_wstrb    = bus_wstrb_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;

    assign inst_addr_ok = addr_hs_s && (gnt_q == GNT_INST);
    assign data_addr_ok = addr_hs_s && (gnt_q == GNT_DATA);
    assign inst_data_ok = data_hs_s && (gnt_q == GNT_INST);
    assign data_data_ok = data_hs_s && (gnt_q == GNT_DATA);
    assign inst_rdata   = inst_data_ok ? bus_rdata : inst_rdata_q;
    assign data_rdata   = data_data_ok ? bus_rdata : data_rdata_q;

    // Gated by rst so the stall request also drops while reset is asserted.
    assign stallreq_for_bus = rst && (((state_q == ARB_IDLE) && (inst_req || data_req)) ||
                                      (state_q == ARB_ADDR) ||
                                      ((state_q == ARB_DATA) && !bus_data_ok));

endmodule
